// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port external SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sram_arb_pkg;

    // Sequencer states: one grant cycle, an upper-half access,
    // a lower-half access, then a single acknowledge cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Byte distance between the upper and lower 16-bit halves of a word.
    localparam int HALF_OFFSET = 2;

    // Requester indices.
    localparam int PORT_CPU  = 0;
    localparam int PORT_DISP = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; purely combinational, the pointer lives in the parent.
// Latency: zero cycles (grant follows req in the same cycle).
// Backpressure: none; a port without a grant simply keeps its request high.
//   req_i  : per-port request
//   prio_i : port favoured when both request (the one not granted last)
//   gnt_o  : one-hot grant, all-zero when nothing is requested
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        unique case (req_i)
            2'b01:   gnt_o[PORT_CPU]  = 1'b1;
            2'b10:   gnt_o[PORT_DISP] = 1'b1;
            2'b11:   gnt_o[prio_i]    = 1'b1;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two 32-bit word requesters onto a 16-bit SRAM, upper half then lower half.
// Latency: ack pulses 2*WAIT cycles after the grant edge; one transaction per 2*WAIT+2 cycles.
// Backpressure: req is a level held until ack; the losing port waits, nothing is dropped.
//   clk/reset            : clock, async active-low reset
//   req/we/addrN/wdataN  : per-port request, write select, byte address, write data
//   rdata/ack/busy       : shared read data (valid with ack), per-port ack pulse, non-idle flag
//   sram_*               : registered SRAM address, write half-word, enables; read half-word in
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic [31:0]       rdata,
    output logic [1:0]        ack,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_adr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_we,
    output logic              sram_oe
);

    localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;     // granted port for the transaction in flight
    logic              wr_q, wr_d;         // latched write select
    logic [ADDR_W-1:0] base_q, base_d;     // latched word-aligned base address
    logic [31:0]       wdat_q, wdat_d;     // latched write data
    logic              ptr_q, ptr_d;       // port favoured on the next tie
    logic [15:0]       hi_q, hi_d;         // upper read half, held until the word completes
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [15:0]       swd_q, swd_d;
    logic              swe_q, swe_d;
    logic              soe_q, soe_d;

    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              phase_end;

    // Byte-lane bits and bits beyond the SRAM range are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:ADDR_W], addr0[1:0], addr1[31:ADDR_W], addr1[1:0]};

    rr_arb2 u_rr_arb2 (
        .req_i  (req),
        .prio_i (ptr_q),
        .gnt_o  (gnt)
    );

    assign gnt_idx   = gnt[PORT_DISP];
    assign phase_end = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        wr_d    = wr_q;
        base_d  = base_q;
        wdat_d  = wdat_q;
        ptr_d   = ptr_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        adr_d   = adr_q;
        swd_d   = '0;
        swe_d   = 1'b0;
        soe_d   = 1'b0;

        // The SRAM-side outputs are computed for the state being entered so
        // that they are registered and only move on state/phase edges.
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    port_d  = gnt_idx;
                    wr_d    = we[gnt_idx];
                    base_d  = gnt_idx ? {addr1[ADDR_W-1:2], 2'b00} : {addr0[ADDR_W-1:2], 2'b00};
                    wdat_d  = gnt_idx ? wdata1 : wdata0;
                    ptr_d   = ~gnt_idx;
                    state_d = ST_HI;
                    cnt_d   = CNT_RELOAD;
                    adr_d   = base_d;
                    swe_d   = wr_d;
                    soe_d   = ~wr_d;
                    swd_d   = wr_d ? wdat_d[31:16] : 16'h0000;
                end
            end
            ST_HI: begin
                swe_d = wr_q;
                soe_d = ~wr_q;
                if (phase_end) begin
                    if (!wr_q) begin
                        hi_d = sram_rdata;
                    end
                    state_d = ST_LO;
                    cnt_d   = CNT_RELOAD;
                    adr_d   = base_q + ADDR_W'(HALF_OFFSET);
                    swd_d   = wr_q ? wdat_q[15:0] : 16'h0000;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    swd_d = wr_q ? wdat_q[31:16] : 16'h0000;
                end
            end
            ST_LO: begin
                if (phase_end) begin
                    // Publish the whole word at once so rdata never shows a torn value.
                    if (!wr_q) begin
                        rdata_d = {hi_q, sram_rdata};
                    end
                    ack_d[port_q] = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    swe_d = wr_q;
                    soe_d = ~wr_q;
                    swd_d = wr_q ? wdat_q[15:0] : 16'h0000;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            base_q  <= '0;
            wdat_q  <= '0;
            ptr_q   <= 1'(PORT_CPU);
            hi_q    <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            adr_q   <= '0;
            swd_q   <= '0;
            swe_q   <= 1'b0;
            soe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            wdat_q  <= wdat_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            adr_q   <= adr_d;
            swd_q   <= swd_d;
            swe_q   <= swe_d;
            soe_q   <= soe_d;
        end
    end

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign busy     = (state_q != ST_IDLE);
    assign sram_adr = adr_q;
    // sram_wdata is zero outside write phases; the chip-level pad ring turns
    // it into the bidirectional bus using sram_we as the output enable.
    assign sram_wdata = swd_q;
    assign sram_we    = swe_q;
    assign sram_oe    = soe_q;

endmodule
